// File: rtl/game_state_ctrl_pkg.sv
// Shared phase encoding and default frame timing for the game sequencer and the HUD.
package game_state_pkg;

    typedef enum logic [2:0] {
        PH_TITLE     = 3'd0,
        PH_RESTART   = 3'd1,
        PH_PLAY      = 3'd2,
        PH_DYING     = 3'd3,
        PH_GAME_OVER = 3'd4
    } game_phase_t;

    localparam int unsigned DEF_DEATH_FRAMES    = 60;
    localparam int unsigned DEF_BLINK_HALF      = 30;
    localparam int unsigned DEF_MIN_SHOW_FRAMES = 90;
    localparam int unsigned DEF_RESET_CYCLES    = 4;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_state_ctrl_rise_detect.sv
// One-cycle rising-edge pulse; the previous-value reset level is configurable so a
// level held through reset can be made to produce no edge.
module rise_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_prev <= RST_VAL;
        else       r_prev <= i_d;
    end

    assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-phase sequencer: title, restart pulse, play, dying delay and blinking game-over
// banner, with all outputs registered from the next-state decode.
module game_state_ctrl
    import game_state_pkg::*;
#(
    parameter int unsigned DEATH_FRAMES    = DEF_DEATH_FRAMES,
    parameter int unsigned BLINK_HALF      = DEF_BLINK_HALF,
    parameter int unsigned MIN_SHOW_FRAMES = DEF_MIN_SHOW_FRAMES,
    parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start_key,
    input  logic       player_dead,
    output logic       Title_On,
    output logic       Play_Enable,
    output logic       Game_Over_On,
    output logic       Game_Reset,
    output logic [2:0] Phase
);

    localparam int unsigned CNT_MAX = max2(max2(DEATH_FRAMES, BLINK_HALF),
                                           max2(MIN_SHOW_FRAMES, RESET_CYCLES));
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t C_DEATH    = cnt_t'(DEATH_FRAMES);
    localparam cnt_t C_BLINK    = cnt_t'(BLINK_HALF);
    localparam cnt_t C_SHOW     = cnt_t'(MIN_SHOW_FRAMES);
    localparam cnt_t C_RST_LAST = cnt_t'(RESET_CYCLES - 1);

    logic        w_frame_tick;
    logic        w_key_rise;

    game_phase_t r_state, w_state;
    cnt_t        r_cyc,   w_cyc;
    cnt_t        r_frm,   w_frm;
    cnt_t        r_blink, w_blink;
    cnt_t        r_show,  w_show;
    logic        r_vis,   w_vis;

    rise_detect #(.RST_VAL(1'b0)) u_frame_rise (
        .i_clk  (Clk),
        .i_rst  (Reset),
        .i_d    (frame_clk),
        .o_rise (w_frame_tick)
    );

    rise_detect #(.RST_VAL(1'b1)) u_key_rise (
        .i_clk  (Clk),
        .i_rst  (Reset),
        .i_d    (start_key),
        .o_rise (w_key_rise)
    );

    always_comb begin
        w_state = r_state;
        w_cyc   = r_cyc;
        w_frm   = r_frm;
        w_blink = r_blink;
        w_show  = r_show;
        w_vis   = r_vis;
        case (r_state)
            PH_TITLE: begin
                if (w_key_rise) begin
                    w_state = PH_RESTART;
                    w_cyc   = '0;
                end
            end
            PH_RESTART: begin
                if (r_cyc == C_RST_LAST) begin
                    w_state = PH_PLAY;
                    w_cyc   = '0;
                end else begin
                    w_cyc = r_cyc + 1'b1;
                end
            end
            PH_PLAY: begin
                if (player_dead) begin
                    w_state = PH_DYING;
                    w_frm   = '0;
                end
            end
            PH_DYING: begin
                if (w_frame_tick) begin
                    w_frm = r_frm + 1'b1;
                    if (r_frm + 1'b1 == C_DEATH) begin
                        w_state = PH_GAME_OVER;
                        w_blink = '0;
                        w_show  = '0;
                        w_vis   = 1'b1;
                    end
                end
            end
            PH_GAME_OVER: begin
                // Key is judged on the show count from before this cycle's tick.
                if (w_key_rise && (r_show == C_SHOW)) begin
                    w_state = PH_RESTART;
                    w_cyc   = '0;
                end else if (w_frame_tick) begin
                    if (r_blink + 1'b1 == C_BLINK) begin
                        w_blink = '0;
                        w_vis   = ~r_vis;
                    end else begin
                        w_blink = r_blink + 1'b1;
                    end
                    if (r_show != C_SHOW) w_show = r_show + 1'b1;
                end
            end
            default: w_state = PH_TITLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= PH_TITLE;
            r_cyc        <= '0;
            r_frm        <= '0;
            r_blink      <= '0;
            r_show       <= '0;
            r_vis        <= 1'b0;
            Title_On     <= 1'b1;
            Play_Enable  <= 1'b0;
            Game_Over_On <= 1'b0;
            Game_Reset   <= 1'b0;
            Phase        <= PH_TITLE;
        end else begin
            r_state      <= w_state;
            r_cyc        <= w_cyc;
            r_frm        <= w_frm;
            r_blink      <= w_blink;
            r_show       <= w_show;
            r_vis        <= w_vis;
            Title_On     <= (w_state == PH_TITLE);
            Play_Enable  <= (w_state == PH_PLAY);
            Game_Over_On <= (w_state == PH_GAME_OVER) && w_vis;
            Game_Reset   <= (w_state == PH_RESTART);
            Phase        <= w_state;
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: vector table for the reset/start path,
// then hand-built sequences for death delay, banner blink, key gating and reset.
module tb_game_state_ctrl;
    import game_state_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       start_key = 1'b1;
    logic       player_dead = 1'b0;
    logic       Title_On, Play_Enable, Game_Over_On, Game_Reset;
    logic [2:0] Phase;

    always #5 Clk = ~Clk;

    game_state_ctrl #(
        .DEATH_FRAMES    (60),
        .BLINK_HALF      (30),
        .MIN_SHOW_FRAMES (90),
        .RESET_CYCLES    (4)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .start_key    (start_key),
        .player_dead  (player_dead),
        .Title_On     (Title_On),
        .Play_Enable  (Play_Enable),
        .Game_Over_On (Game_Over_On),
        .Game_Reset   (Game_Reset),
        .Phase        (Phase)
    );

    typedef struct packed {
        logic [2:0] phase;
        logic       title;
        logic       play;
        logic       go;
        logic       grst;
    } exp_t;

    typedef struct {
        logic rst;
        logic frm;
        logic key;
        logic dead;
        exp_t e;
    } vec_t;

    localparam exp_t E_TITLE  = '{3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam exp_t E_RST    = '{3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam exp_t E_PLAY   = '{3'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam exp_t E_DYING  = '{3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t E_GO_ON  = '{3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam exp_t E_GO_OFF = '{3'd4, 1'b0, 1'b0, 1'b0, 1'b0};

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   stepn = 0;
    vec_t tbl[12];

    // Drive one cycle of inputs, queue the expectation, compare it after the edge.
    task automatic step(input logic rst, input logic frm, input logic key, input logic dead,
                        input exp_t e, input string name);
        exp_t got;
        exp_t want;
        Reset       = rst;
        frame_clk   = frm;
        start_key   = key;
        player_dead = dead;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        stepn++;
        got = {Phase, Title_On, Play_Enable, Game_Over_On, Game_Reset};
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s (step %0d): scoreboard empty, got %b", name, stepn, got);
        end else begin
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL %s (step %0d): phase/title/play/go/rst got %b required %b",
                         name, stepn, got, want);
            end
        end
    endtask

    task automatic frame(input logic dead, input exp_t e, input string name);
        step(1'b0, 1'b1, 1'b0, dead, e, name);
        step(1'b0, 1'b0, 1'b0, dead, e, name);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, E_TITLE};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, E_TITLE};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, E_TITLE};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, E_TITLE};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, E_RST};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, E_RST};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, E_RST};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, E_RST};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, E_PLAY};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, E_PLAY};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, E_DYING};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, E_DYING};

        for (int i = 0; i < 12; i++)
            step(tbl[i].rst, tbl[i].frm, tbl[i].key, tbl[i].dead, tbl[i].e, "vector_table");

        // Game 1: exact death delay, then 120 banner ticks.
        for (int i = 1; i <= 60; i++)
            frame(1'b0, (i < 60) ? E_DYING : E_GO_ON, "death_count");
        for (int k = 1; k <= 120; k++)
            frame(1'b0, (((k / 30) % 2) == 0) ? E_GO_ON : E_GO_OFF, "blink_120");

        step(1'b0, 1'b0, 1'b1, 1'b0, E_RST, "key_after_saturation");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, E_RST, "restart_len_dead_ignored");
        step(1'b0, 1'b0, 1'b0, 1'b1, E_PLAY, "first_play_cycle");
        step(1'b0, 1'b0, 1'b0, 1'b1, E_DYING, "dead_on_first_play");

        // Game 2: a frame_clk level held for 100 cycles counts once.
        step(1'b0, 1'b1, 1'b0, 1'b1, E_DYING, "held_rise");
        for (int i = 1; i < 100; i++)
            step(1'b0, 1'b1, 1'b0, 1'b1, E_DYING, "held_high");
        step(1'b0, 1'b0, 1'b0, 1'b1, E_DYING, "held_fall");
        for (int i = 2; i <= 60; i++)
            frame(1'b0, (i < 60) ? E_DYING : E_GO_ON, "held_count");

        for (int k = 1; k <= 89; k++)
            frame(1'b0, (((k / 30) % 2) == 0) ? E_GO_ON : E_GO_OFF, "blink_89");
        step(1'b0, 1'b0, 1'b1, 1'b1, E_GO_ON,  "key_at_show_89");
        step(1'b0, 1'b0, 1'b0, 1'b0, E_GO_ON,  "key_release_1");
        step(1'b0, 1'b1, 1'b1, 1'b0, E_GO_OFF, "key_on_saturating_tick");
        step(1'b0, 1'b0, 1'b0, 1'b0, E_GO_OFF, "key_release_2");
        step(1'b0, 1'b0, 1'b1, 1'b0, E_RST,    "key_accepted");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, E_RST, "restart2_len");
        step(1'b0, 1'b0, 1'b0, 1'b0, E_PLAY, "play2_entry");
        step(1'b0, 1'b1, 1'b0, 1'b0, E_PLAY, "play2_hold");

        // Reset from PLAY, then again during the second RESTART cycle.
        step(1'b1, 1'b0, 1'b0, 1'b0, E_TITLE, "reset_in_play");
        step(1'b0, 1'b0, 1'b0, 1'b0, E_TITLE, "title_idle");
        step(1'b0, 1'b0, 1'b1, 1'b0, E_RST,   "restart3_c1");
        step(1'b0, 1'b0, 1'b1, 1'b0, E_RST,   "restart3_c2");
        step(1'b1, 1'b0, 1'b1, 1'b0, E_TITLE, "reset_mid_restart");
        step(1'b0, 1'b0, 1'b1, 1'b0, E_TITLE, "title_key_held_through_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level game-phase sequencer.
- Drives the overlay enables (title screen, game-over banner), gates gameplay logic, and issues a synchronous restart pulse to the playfield/score/enemy blocks.
- Timing is counted in frames using the VGA vertical-sync pulse, sampled in the Clk domain.
- Sits beside the sprite/overlay renderers. Its Game_Over_On output feeds the game-over overlay renderer directly.

Parameters:
- DEATH_FRAMES, 60: frame ticks spent in DYING before the banner appears.
- BLINK_HALF, 30: frame ticks per banner on/off half-period.
- MIN_SHOW_FRAMES, 90: frame ticks in GAME_OVER before a restart key is accepted.
- RESET_CYCLES, 4: Clk cycles that Game_Reset stays asserted in RESTART.

Ports:
- Clk, input, 1: system clock. Single clock domain.
- Reset, input, 1: synchronous, active-high reset.
- frame_clk, input, 1: VGA vsync-derived level. Its rising edge is one frame tick.
- start_key, input, 1: debounced start/restart key level, high = pressed.
- player_dead, input, 1: level from the player block, high = health exhausted.
- Title_On, output, 1: enables the title overlay.
- Play_Enable, output, 1: gameplay logic may update.
- Game_Over_On, output, 1: enables the game-over overlay, blink-gated.
- Game_Reset, output, 1: restart pulse to game datapath blocks.
- Phase, output, 3: current state encoding, for the HUD and debug.

Behaviour:
- All outputs are Moore-decoded from registered state and counters. There is no combinational input-to-output path.
- Edge detection:
  - frame_tick = frame_clk & ~frame_prev.
  - key_rise = start_key & ~key_prev.
  - Each is one Clk cycle wide.
  - On Reset, frame_prev is cleared to 0 and key_prev is set to 1, so a key held through reset does not produce an edge.
- Reset value (cycle after Reset is sampled high):
  - state=TITLE, Title_On=1, Play_Enable=0, Game_Over_On=0, Game_Reset=0.
  - All counters are 0.
- TITLE: Title_On=1. key_rise -> RESTART.
- RESTART:
  - Game_Reset=1 for exactly RESET_CYCLES consecutive cycles.
  - Then -> PLAY with the cycle counter cleared.
  - Input events in this state are ignored.
- PLAY:
  - Play_Enable=1.
  - player_dead sampled high -> DYING, frame counter cleared.
  - If player_dead is high on the first PLAY cycle, take the transition anyway.
- DYING:
  - Play_Enable=0.
  - Count frame ticks. On the tick that makes the count equal DEATH_FRAMES -> GAME_OVER.
  - Entering GAME_OVER clears the blink counter and show counter and sets blink_vis=1.
- GAME_OVER:
  - Game_Over_On = blink_vis.
  - Each frame tick increments the blink counter. When it reaches BLINK_HALF, blink_vis toggles and the blink counter clears.
  - The show counter increments per frame tick and saturates at MIN_SHOW_FRAMES.
  - key_rise is accepted only if the show counter was already equal to MIN_SHOW_FRAMES at the start of that cycle. A key on the same cycle as the saturating tick is ignored.
  - An accepted key -> RESTART.
  - player_dead is ignored here.
- Simultaneous events:
  - In PLAY, player_dead wins over everything.
  - In GAME_OVER, when key and tick coincide, the key is evaluated against pre-update counters.
- Reset mid-operation (any state, including mid-RESTART): the next cycle is TITLE and Game_Reset drops immediately.
- Phase encoding: TITLE=0, RESTART=1, PLAY=2, DYING=3, GAME_OVER=4.
- Counter widths: $clog2(max param + 1). No wrap is reachable because counters either clear on threshold or saturate.

Decomposition:
- game_state_pkg contains:
  - typedef enum logic [2:0] game_phase_t with the encodings above.
  - Default timing constants shared with the HUD.
- Sub-module rise_detect (registered previous value plus AND; reset value of the previous-value register is a parameter). It is instantiated twice, for frame_clk and start_key.

Test Plan:
- Reset with start_key held high, then release and press once -> no RESTART while held; the press yields Phase=1 and Game_Reset high for exactly 4 cycles, then Phase=2 and Play_Enable=1.
- In PLAY, assert player_dead -> next cycle Phase=3 and Play_Enable=0. After exactly 60 frame_clk rising edges, Phase=4 and Game_Over_On=1.
- In GAME_OVER, run 120 frame ticks -> Game_Over_On pattern is 30 on, 30 off, 30 on, 30 off, with toggles on the ticks numbered 30, 60 and 90.
- Press start_key at show count 89 and again on the tick that makes it 90 -> both ignored. Press again one cycle later -> RESTART with a 4-cycle Game_Reset, then PLAY.
- Assert Reset during the 2nd cycle of RESTART -> next cycle Phase=0, Title_On=1, Game_Reset=0.
- Hold frame_clk high for 100 Clk cycles -> exactly one frame tick counted.
